// File: rtl/mem_arbiter_if.sv
// Bundled handshake signals between the requesters, the memory array and mem_arbiter.
// The arbiter attaches through the slave modport, and the requester/memory side attaches through master.
interface mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                  flash_en;
    logic [ADDR_WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0]      flash_data;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [WIDTH-1:0]      if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [WIDTH-1:0]      d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [WIDTH-1:0]      d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;

    modport slave (
        input  flash_en, flash_addr, flash_data,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output flash_en, flash_addr, flash_data,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: an unconditional flash write path, plus instruction fetch and data requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating fetch/data grants; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t state;
    logic   rvalid_if_q;
    logic   rvalid_d_q;
    logic   grant_ok;
    logic   if_win;
    logic   d_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic   ptr_data;  // 0: fetch wins the next tie, 1: data wins it

    assign if_win = bus.if_req & (~bus.d_req | ~ptr_data);
    assign d_win  = bus.d_req  & (~bus.if_req | ptr_data);
`else
    assign if_win = bus.if_req & ~bus.d_req;
    assign d_win  = bus.d_req;
`endif

    // The flash path owns the memory port whenever it pulses, so no grant is issued that cycle.
    assign grant_ok   = (state == IDLE) & ~rst & ~bus.flash_en;
    assign bus.if_gnt = grant_ok & if_win;
    assign bus.d_gnt  = grant_ok & d_win;

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.flash_en) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.flash_addr;
            bus.mem_wdata = bus.flash_data;
        end else if (bus.if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr;
        end else if (bus.d_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rvalid_if_q <= 1'b0;
            rvalid_d_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_data    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rvalid_if_q <= bus.if_gnt;
                    rvalid_d_q  <= bus.d_gnt & ~bus.d_we;
                    if (bus.if_gnt || (bus.d_gnt && !bus.d_we)) state <= RD_WAIT;
                end
                default: begin
                    rvalid_if_q <= 1'b0;
                    rvalid_d_q  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (bus.if_gnt)     ptr_data <= 1'b1;
            else if (bus.d_gnt) ptr_data <= 1'b0;
`endif
        end
    end

    // A read pending in RD_WAIT is discarded as soon as reset is asserted.
    assign bus.if_rvalid = rvalid_if_q & ~rst;
    assign bus.d_rvalid  = rvalid_d_q & ~rst;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency memory model on the memory port.
// Tie-break expectations follow MEM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_arbiter;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 11;
    localparam logic [WIDTH-1:0] INSN = 32'h0280_2783;
    localparam logic [WIDTH-1:0] BEEF = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem_model [0:511];
    logic [WIDTH-1:0] rdata_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr[10:2]] <= bus.mem_wdata;
            else            rdata_q <= mem_model[bus.mem_addr[10:2]];
        end
    end
    assign bus.mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flash_en   = 1'b0;
        bus.flash_addr = '0;
        bus.flash_data = '0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
    endtask

    task automatic flash(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        bus.flash_en   = 1'b1;
        bus.flash_addr = a;
        bus.flash_data = d;
    endtask

    logic [5:0] exp_if_gnt;
    logic [5:0] exp_d_gnt;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state with no traffic
        @(negedge clk);
        check("rst_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
        check("rst_d_gnt", {31'b0, bus.d_gnt}, 32'd0);
        check("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        check("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
        tick();

        // Flash write during reset, with a fetch request present
        flash(11'd40, 32'h1);
        bus.if_req = 1'b1;
        @(negedge clk);
        check("rstflash_mem_en", {31'b0, bus.mem_en}, 32'd1);
        check("rstflash_mem_we", {31'b0, bus.mem_we}, 32'd1);
        check("rstflash_mem_addr", {21'b0, bus.mem_addr}, 32'd40);
        check("rstflash_mem_wdata", bus.mem_wdata, 32'h1);
        check("rstflash_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
        tick();
        idle_inputs();
        flash(11'd0, INSN);
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();

        // Fetch read at address 0
        bus.if_req  = 1'b1;
        bus.if_addr = 11'd0;
        @(negedge clk);
        check("fetch_if_gnt_n", {31'b0, bus.if_gnt}, 32'd1);
        check("fetch_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("fetch_mem_addr", {21'b0, bus.mem_addr}, 32'd0);
        tick();
        @(negedge clk);
        check("fetch_if_gnt_n1", {31'b0, bus.if_gnt}, 32'd0);
        check("fetch_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
        check("fetch_if_rdata", bus.if_rdata, INSN);
        check("fetch_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("fetch_rvalid_drop", {31'b0, bus.if_rvalid}, 32'd0);
        tick();

        // Data write, then an immediate data read proving the FSM stayed in IDLE
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 11'd36;
        bus.d_wdata = BEEF;
        @(negedge clk);
        check("dwr_d_gnt", {31'b0, bus.d_gnt}, 32'd1);
        check("dwr_mem_we", {31'b0, bus.mem_we}, 32'd1);
        check("dwr_mem_addr", {21'b0, bus.mem_addr}, 32'd36);
        check("dwr_mem_wdata", bus.mem_wdata, BEEF);
        tick();
        bus.d_we    = 1'b0;
        bus.d_wdata = '0;
        @(negedge clk);
        check("dwr_d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        check("drd_d_gnt_idle", {31'b0, bus.d_gnt}, 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("drd_d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
        check("drd_d_rdata", bus.d_rdata, BEEF);
        tick();

        // Simultaneous fetch and data reads held for 6 cycles
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_if_gnt = 6'b010001;
        exp_d_gnt  = 6'b000100;
`else
        exp_if_gnt = 6'b000000;
        exp_d_gnt  = 6'b010101;
`endif
        bus.if_req  = 1'b1;
        bus.if_addr = 11'd0;
        bus.d_req   = 1'b1;
        bus.d_addr  = 11'd36;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("tie_if_gnt_c%0d", c), {31'b0, bus.if_gnt}, {31'b0, exp_if_gnt[c]});
            check($sformatf("tie_d_gnt_c%0d", c), {31'b0, bus.d_gnt}, {31'b0, exp_d_gnt[c]});
            if (c > 0) begin
                check($sformatf("tie_if_rvalid_c%0d", c), {31'b0, bus.if_rvalid}, {31'b0, exp_if_gnt[c-1]});
                check($sformatf("tie_d_rvalid_c%0d", c), {31'b0, bus.d_rvalid}, {31'b0, exp_d_gnt[c-1]});
                if (exp_if_gnt[c-1]) check($sformatf("tie_if_rdata_c%0d", c), bus.if_rdata, INSN);
                if (exp_d_gnt[c-1])  check($sformatf("tie_d_rdata_c%0d", c), bus.d_rdata, BEEF);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Flash write colliding with a fetch in IDLE
        flash(11'd8, 32'h55);
        bus.if_req  = 1'b1;
        bus.if_addr = 11'd8;
        @(negedge clk);
        check("coll_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
        check("coll_mem_we", {31'b0, bus.mem_we}, 32'd1);
        check("coll_mem_addr", {21'b0, bus.mem_addr}, 32'd8);
        tick();
        bus.flash_en = 1'b0;
        @(negedge clk);
        check("coll_if_gnt_next", {31'b0, bus.if_gnt}, 32'd1);
        check("coll_mem_we_next", {31'b0, bus.mem_we}, 32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("coll_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
        check("coll_if_rdata", bus.if_rdata, 32'h55);
        tick();

        // Reset arriving while a read is pending
        bus.if_req  = 1'b1;
        bus.if_addr = 11'd0;
        @(negedge clk);
        check("rstrd_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        tick();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rstrd_if_rvalid_in_rst", {31'b0, bus.if_rvalid}, 32'd0);
        check("rstrd_d_rvalid_in_rst", {31'b0, bus.d_rvalid}, 32'd0);
        tick();
        rst = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 11'd36;
        @(negedge clk);
        check("rstrd_if_rvalid_after", {31'b0, bus.if_rvalid}, 32'd0);
        check("rstrd_d_gnt_idle", {31'b0, bus.d_gnt}, 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("rstrd_d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
        check("rstrd_d_rdata", bus.d_rdata, BEEF);
        check("rstrd_if_rvalid_late", {31'b0, bus.if_rvalid}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, byte address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flash_en, input, 1, one-cycle pulse requesting a flash write.
REQ-006 SHALL have port flash_addr, input, ADDR_WIDTH, flash write address.
REQ-007 SHALL have port flash_data, input, WIDTH, flash write data.
REQ-008 SHALL have port if_req, input, 1, instruction fetch read request.
REQ-009 SHALL have port if_addr, input, ADDR_WIDTH, fetch address.
REQ-010 SHALL have ports if_gnt (output, 1, request accepted), if_rvalid (output, 1, read data valid) and if_rdata (output, WIDTH, fetched word).
REQ-011 SHALL have ports d_req, d_we, d_addr and d_wdata, inputs, widths 1/1/ADDR_WIDTH/WIDTH, data-side request, write enable, address and write data.
REQ-012 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, WIDTH), data-side accept, read valid and read data.
REQ-013 SHALL have memory-side ports mem_en, mem_we, mem_addr and mem_wdata, outputs, widths 1/1/ADDR_WIDTH/WIDTH, plus mem_rdata, input, WIDTH; memory read latency is 1 cycle.

Function
REQ-014 SHALL implement FSM states IDLE and RD_WAIT.
REQ-015 SHALL accept flash_en in the same cycle it is asserted, in any state and while rst=1, driving mem_en=1, mem_we=1 and flash_addr/flash_data; no backpressure.
REQ-016 SHALL, in IDLE with flash_en=1, grant no other requester that cycle.
REQ-017 SHALL, in IDLE without flash_en and with rst=0, grant one of if_req/d_req per the priority rule: gnt combinational, memory access issued that cycle.
REQ-018 SHALL complete a granted data write (d_we=1) in the grant cycle, stay in IDLE, and assert no rvalid.
REQ-019 SHALL, on a granted read, register the owner, move to RD_WAIT, and next cycle assert that owner's rvalid for exactly 1 cycle, with rdata=mem_rdata.
REQ-020 SHALL return from RD_WAIT to IDLE unconditionally; no fetch/data grant in RD_WAIT (max read throughput 1 per 2 cycles).
REQ-021 SHALL drive if_rdata/d_rdata as mem_rdata passthrough, meaningful only when the matching rvalid=1.
REQ-022 SHALL require requesters to hold req, addr, we and wdata stable until gnt; the arbiter does not latch un-granted requests.
REQ-023 SHALL hold mem_en=0, all gnt=0 and mem_addr/mem_wdata don't-care when no access is issued.

Reset
REQ-024 SHALL on rst=1 set state IDLE, if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, and round-robin pointer to fetch-first.
REQ-025 SHALL discard a read pending in RD_WAIT when rst asserts; no rvalid follows.
REQ-026 SHALL keep the flash path functional during rst (REQ-015).

Configuration
REQ-027 SHALL, when macro MEM_ARB_ROUND_ROBIN_EN is defined, alternate grants between fetch and data on simultaneous requests, with the pointer flipping after each fetch or data grant.
REQ-028 SHALL, without MEM_ARB_ROUND_ROBIN_EN, give data fixed priority over fetch on simultaneous requests; no pointer state.

Verification
REQ-029 SHALL cover: rst=1, flash_en pulse addr=40 data=0x1 -> mem_en=1, mem_we=1, mem_addr=40, mem_wdata=0x1 same cycle, if_gnt=0.
REQ-030 SHALL cover: rst=0, if_req addr=0, mem holds 0x02802783 -> if_gnt cycle N, if_rvalid=1 with if_rdata=0x02802783 at N+1, if_gnt=0 at N+1.
REQ-031 SHALL cover: d_req with d_we=1, addr=36, wdata=0xDEADBEEF -> d_gnt and mem write same cycle, d_rvalid stays 0, state stays IDLE.
REQ-032 SHALL cover: if_req and d_req reads held 6 cycles -> with macro, grants alternate starting with fetch (F, D, F); without macro, D, D, D.
REQ-033 SHALL cover: flash_en in the same cycle as if_req in IDLE -> flash written, if_gnt=0, fetch granted the next cycle.
REQ-034 SHALL cover: read granted, rst asserted the next cycle -> if_rvalid=d_rvalid=0 and state IDLE after reset.
